lzc_stream: RTL and testbench
=============================

Name: lzc_stream

Overview:
- Pipelined, parametrised leading/trailing zero/one counter with valid/ready streaming handshake.
- Successor to the combinational classic LZC tree.
- Adds arbitrary WIDTH (no power-of-two restriction), selectable count mode per transaction, configurable pipeline depth with full backpressure, and a normalised (shifted) operand output for FP normalisation and priority-encode paths.

Parameters:
- WIDTH, 16, operand width in bits, >= 2, any value. Internally padded to WIDTH2 = 2**$clog2(WIDTH).
- STAGES, 2, register stages from input to output, 1..$clog2(WIDTH2)+1. Tree levels are split evenly across stages; the last stage is the output register.
- CW, $clog2(WIDTH+1), count width (derived; not to be overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_data  in  WIDTH  operand.
- in_mode  in  2  00 = leading zeros, 01 = leading ones, 10 = trailing zeros, 11 = trailing ones.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_cnt  out  CW  count, range 0..WIDTH.
- out_zero  out  1  no bit of the counted polarity present; out_cnt == WIDTH.
- out_norm  out  WIDTH  normalised operand.
- out_mode  out  2  mode carried with the beat.

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high, and overrides all other inputs.
- Reset state: every stage valid bit = 0. out_valid = 0; out_cnt, out_zero, out_norm and out_mode = 0; in_ready = 1 in the cycle after reset deasserts.
- Reset mid-stream: all in-flight beats are discarded with no output.
- Handshake: a beat transfers on a cycle with valid && ready on either side. out_* are held stable while out_valid && !out_ready.
- Elastic pipeline: stage k loads when it is empty or when stage k+1 loads or drains this cycle. in_ready = !stage1_valid || stage1_advances. in_ready does not depend combinationally on in_valid.
- Latency and throughput: latency is STAGES cycles, accept to out_valid, with no backpressure. Throughput is 1 beat/cycle. A full pipe holds exactly STAGES beats; no beat is dropped or duplicated, and order is preserved.
- Mode pre-transform (stage 1, combinational before the tree):
  - 01 and 11 invert the operand.
  - 10 and 11 bit-reverse the operand.
  - The result is padded with 1s in the (WIDTH2-WIDTH) LSBs, so the count saturates at WIDTH.
- Tree: classic two-input base-element tree of $clog2(WIDTH2) levels. out_zero is computed from the WIDTH real bits only.
- Count: out_cnt = number of consecutive counted-polarity bits from the selected end. out_zero = 1 exactly when out_cnt == WIDTH.
- Normalisation (final stage, from the original in_data carried down the pipe):
  - Modes 00/01: out_norm = in_data << out_cnt.
  - Modes 10/11: out_norm = in_data >> out_cnt.
  - Both are logical shifts, with zero fill.
  - out_zero forces out_norm = 0.
- Simultaneous events: accept and output on the same cycle with a full pipe sustains full rate. rst takes priority over in_valid and out_ready.
- Output register: out_valid and the data outputs are registered. There is no combinational path from in_* to out_*.

Test Plan:
- Latency, mode 00 (WIDTH=16, STAGES=2): in_data=0x0001, mode 00, out_ready=1 -> out_valid exactly 2 cycles after accept; out_cnt=15, out_zero=0, out_norm=0x8000.
- All-zero and saturation: in_data=0x0000, mode 00 -> cnt=16, zero=1, norm=0x0000. Then 0xFFFF mode 01 -> cnt=16, zero=1, norm=0x0000. Then 0x8000 mode 00 -> cnt=0, norm=0x8000.
- Trailing modes: 0x0100 mode 10 -> cnt=8, norm=0x0001. 0x00FF mode 11 -> cnt=8, norm=0x0000, zero=0. 0xF0FF mode 01 -> cnt=4, norm=0x0FF0.
- Non-power-of-two width (WIDTH=12, STAGES=3): 0x000 mode 00 -> cnt=12, zero=1. 0x001 mode 00 -> cnt=11, norm=0x800. 0x800 mode 10 -> cnt=11, norm=0x001.
- Backpressure: stream 6 beats back-to-back with out_ready low for cycles 3-6 -> in_ready low once 2 beats are held; all 6 results exit in order with no drop or duplication; out_* stable while stalled; full rate after release.
- Reset mid-stream: assert rst for 1 cycle with 2 beats in flight -> out_valid=0 the next cycle, no stale result ever appears, in_ready=1 after reset; a fresh beat gives the correct result at latency 2.

Source files
------------

// File: rtl/lzc_stream.sv
// Elastic, pipelined leading/trailing zero/one counter with a normalised operand output.
// The zero-search tree is split across STAGES registers; the last register is the output stage.
module lzc_stream #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2,
   parameter int CW     = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CW-1:0]    out_cnt,
   output logic             out_zero,
   output logic [WIDTH-1:0] out_norm,
   output logic [1:0]       out_mode
);

   localparam int LEVELS = $clog2(WIDTH);
   localparam int WIDTH2 = 1 << LEVELS;
   localparam int LW     = LEVELS;
   localparam int LAST   = STAGES - 1;
   localparam int NI     = (STAGES > 1) ? STAGES - 1 : 1;

   // Node j of a level covers bits [j*2^k +: 2^k]; v = a one exists, c = zeros above it.
   typedef struct packed {
      logic [WIDTH2-1:0]         v;
      logic [WIDTH2-1:0][LW-1:0] c;
   } tree_t;

   function automatic int seg_of(input int lvl);
      return (lvl * STAGES) / LEVELS;
   endfunction

   function automatic tree_t tree_level(input tree_t t, input int k);
      tree_t r;
      r = '0;
      for (int j = 0; j < WIDTH2 / 2; j++) begin
         if (j < (WIDTH2 >> (k + 1))) begin
            r.v[j] = t.v[2*j+1] | t.v[2*j];
            r.c[j] = t.v[2*j+1] ? t.c[2*j+1] : (t.c[2*j] | LW'(1 << k));
         end
      end
      return r;
   endfunction

   logic [WIDTH-1:0]  w_rev;
   logic [WIDTH-1:0]  w_xf;
   logic [WIDTH2-1:0] w_pad;
   logic              w_pre_zero;
   tree_t             w_pre;

   tree_t             r_tree [NI];
   logic [WIDTH-1:0]  r_data [NI];
   logic [1:0]        r_mode [NI];
   logic              r_zero [NI];
   logic [STAGES-1:0] r_vld;

   tree_t             w_sout [STAGES];
   logic [WIDTH-1:0]  w_din  [STAGES];
   logic [1:0]        w_min  [STAGES];
   logic              w_zin  [STAGES];
   logic [STAGES-1:0] w_vin;
   logic [STAGES-1:0] w_load;

   logic [CW-1:0]     w_cnt;
   logic [WIDTH-1:0]  w_norm;
   logic [CW-1:0]     r_out_cnt;
   logic              r_out_zero;
   logic [WIDTH-1:0]  r_out_norm;
   logic [1:0]        r_out_mode;
   logic              w_unused;

   // Mode pre-transform: the tree always looks for the first 1 from the MSB.
   // Padding LSBs with 1s caps the count at WIDTH for non-power-of-two widths.
   always_comb begin
      w_rev = '0;
      for (int i = 0; i < WIDTH; i++) w_rev[i] = in_data[WIDTH-1-i];
      w_xf = in_mode[1] ? w_rev : in_data;
      if (in_mode[0]) w_xf = ~w_xf;
      w_pre_zero = ~|w_xf;
      w_pad = '1;
      w_pad[WIDTH2-1 -: WIDTH] = w_xf;
      w_pre = '0;
      w_pre.v = w_pad;
   end

   always_comb begin
      for (int s = 0; s < STAGES; s++) begin
         w_vin[s] = (s == 0) ? in_valid   : r_vld[(s > 0) ? s - 1 : 0];
         w_din[s] = (s == 0) ? in_data    : r_data[(s > 0) ? s - 1 : 0];
         w_min[s] = (s == 0) ? in_mode    : r_mode[(s > 0) ? s - 1 : 0];
         w_zin[s] = (s == 0) ? w_pre_zero : r_zero[(s > 0) ? s - 1 : 0];
         w_sout[s] = (s == 0) ? w_pre : r_tree[(s > 0) ? s - 1 : 0];
         for (int l = 0; l < LEVELS; l++) begin
            if (seg_of(l) == s) w_sout[s] = tree_level(w_sout[s], l);
         end
      end
   end

   // A stage loads when empty or when the stage after it loads or drains.
   always_comb begin
      w_load = '0;
      w_load[LAST] = !r_vld[LAST] || out_ready;
      for (int s = STAGES - 2; s >= 0; s--) w_load[s] = !r_vld[s] || w_load[s+1];
   end

   assign in_ready = w_load[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld <= '0;
      end else begin
         for (int s = 0; s < STAGES; s++) begin
            if (w_load[s]) r_vld[s] <= w_vin[s];
         end
      end
   end

   // ---- intermediate stages ----
   always_ff @(posedge clk) begin
      for (int s = 0; s < STAGES - 1; s++) begin
         if (w_load[s]) begin
            r_tree[s] <= w_sout[s];
            r_data[s] <= w_din[s];
            r_mode[s] <= w_min[s];
            r_zero[s] <= w_zin[s];
         end
      end
   end

   always_comb begin
      w_cnt  = w_zin[LAST] ? CW'(WIDTH) : CW'(w_sout[LAST].c[0]);
      w_norm = '0;
      if (!w_zin[LAST]) w_norm = w_min[LAST][1] ? (w_din[LAST] >> w_cnt) : (w_din[LAST] << w_cnt);
   end

   // ---- output stage ----
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_cnt  <= '0;
         r_out_zero <= 1'b0;
         r_out_norm <= '0;
         r_out_mode <= '0;
      end else if (w_load[LAST] && w_vin[LAST]) begin
         r_out_cnt  <= w_cnt;
         r_out_zero <= w_zin[LAST];
         r_out_norm <= w_norm;
         r_out_mode <= w_min[LAST];
      end
   end

   always_comb begin
      w_unused = ^w_sout[LAST];
      for (int s = 0; s < STAGES - 1; s++) w_unused = w_unused ^ (^r_tree[s]);
   end

   assign out_valid = r_vld[LAST];
   assign out_cnt   = r_out_cnt;
   assign out_zero  = r_out_zero;
   assign out_norm  = r_out_norm;
   assign out_mode  = r_out_mode;

endmodule

// File: tb/tb_lzc_stream.sv
// Scoreboard bench for lzc_stream: a 16-bit/2-stage instance and a 12-bit/3-stage instance.
module tb_lzc_stream;

   typedef struct {
      logic [15:0] d;
      logic [1:0]  m;
      int          cnt;
      bit          z;
      int          n;
   } vec_t;

   typedef struct {
      int         cnt;
      bit         zero;
      int         norm;
      logic [1:0] mode;
      int         acc;
      bit         lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_zero;
   logic [15:0] a_in_data, a_out_norm;
   logic [1:0]  a_in_mode, a_out_mode;
   logic [4:0]  a_out_cnt;

   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_zero;
   logic [11:0] b_in_data, b_out_norm;
   logic [1:0]  b_in_mode, b_out_mode;
   logic [3:0]  b_out_cnt;

   lzc_stream #(.WIDTH(16), .STAGES(2)) u_a (
      .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_data(a_in_data), .in_mode(a_in_mode), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .out_cnt(a_out_cnt), .out_zero(a_out_zero),
      .out_norm(a_out_norm), .out_mode(a_out_mode)
   );

   lzc_stream #(.WIDTH(12), .STAGES(3)) u_b (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .in_mode(b_in_mode), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_cnt(b_out_cnt), .out_zero(b_out_zero),
      .out_norm(b_out_norm), .out_mode(b_out_mode)
   );

   int   n_pass = 0;
   int   n_total = 0;
   int   cyc = 0;
   int   a_nout = 0;
   exp_t qa[$];
   exp_t qb[$];

   vec_t ta [13] = '{
      '{16'h0000, 2'b00, 16, 1'b1, 'h0000},
      '{16'hFFFF, 2'b01, 16, 1'b1, 'h0000},
      '{16'h8000, 2'b00,  0, 1'b0, 'h8000},
      '{16'h0100, 2'b10,  8, 1'b0, 'h0001},
      '{16'h00FF, 2'b11,  8, 1'b0, 'h0000},
      '{16'hF0FF, 2'b01,  4, 1'b0, 'h0FF0},
      '{16'h1234, 2'b10,  2, 1'b0, 'h048D},
      '{16'h7FFF, 2'b01,  0, 1'b0, 'h7FFF},
      '{16'h0010, 2'b00, 11, 1'b0, 'h8000},
      '{16'h0003, 2'b11,  2, 1'b0, 'h0000},
      '{16'hFFFE, 2'b01, 15, 1'b0, 'h0000},
      '{16'h0001, 2'b10,  0, 1'b0, 'h0001},
      '{16'h8000, 2'b10, 15, 1'b0, 'h0001}
   };

   vec_t tbp [6] = '{
      '{16'h0001, 2'b00, 15, 1'b0, 'h8000},
      '{16'h0000, 2'b00, 16, 1'b1, 'h0000},
      '{16'hFFFF, 2'b01, 16, 1'b1, 'h0000},
      '{16'h8000, 2'b00,  0, 1'b0, 'h8000},
      '{16'h0100, 2'b10,  8, 1'b0, 'h0001},
      '{16'h00FF, 2'b11,  8, 1'b0, 'h0000}
   };

   vec_t tb12 [9] = '{
      '{16'h0001, 2'b00, 11, 1'b0, 'h800},
      '{16'h0000, 2'b00, 12, 1'b1, 'h000},
      '{16'h0800, 2'b10, 11, 1'b0, 'h001},
      '{16'h0FFF, 2'b11, 12, 1'b1, 'h000},
      '{16'h00F0, 2'b01,  0, 1'b0, 'h0F0},
      '{16'h00F0, 2'b10,  4, 1'b0, 'h00F},
      '{16'h0C00, 2'b01,  2, 1'b0, 'h000},
      '{16'h07FF, 2'b00,  1, 1'b0, 'hFFE},
      '{16'h0001, 2'b11,  1, 1'b0, 'h000}
   };

   function automatic void chk(input string name, input bit ok, input int act, input int req);
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Monitors: compare the head of the queue on every valid cycle (also while stalled).
   always @(negedge clk) begin
      if (a_out_valid) begin
         if (qa.size() == 0) begin
            chk("a_unexpected_out", 1'b0, int'(a_out_cnt), -1);
         end else begin
            chk("a_cnt",  int'(a_out_cnt) == qa[0].cnt, int'(a_out_cnt), qa[0].cnt);
            chk("a_zero", a_out_zero == qa[0].zero, int'(a_out_zero), int'(qa[0].zero));
            chk("a_norm", int'(a_out_norm) == qa[0].norm, int'(a_out_norm), qa[0].norm);
            chk("a_mode", a_out_mode == qa[0].mode, int'(a_out_mode), int'(qa[0].mode));
            if (a_out_ready) begin
               if (qa[0].lat) chk("a_latency", (cyc - qa[0].acc) == 2, cyc - qa[0].acc, 2);
               void'(qa.pop_front());
               a_nout++;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (b_out_valid) begin
         if (qb.size() == 0) begin
            chk("b_unexpected_out", 1'b0, int'(b_out_cnt), -1);
         end else begin
            chk("b_cnt",  int'(b_out_cnt) == qb[0].cnt, int'(b_out_cnt), qb[0].cnt);
            chk("b_zero", b_out_zero == qb[0].zero, int'(b_out_zero), int'(qb[0].zero));
            chk("b_norm", int'(b_out_norm) == qb[0].norm, int'(b_out_norm), qb[0].norm);
            chk("b_mode", b_out_mode == qb[0].mode, int'(b_out_mode), int'(qb[0].mode));
            if (b_out_ready) begin
               if (qb[0].lat) chk("b_latency", (cyc - qb[0].acc) == 3, cyc - qb[0].acc, 3);
               void'(qb.pop_front());
            end
         end
      end
   end

   task automatic send_a(input vec_t v, input bit lat, output int acc);
      exp_t e;
      int   k;
      a_in_valid = 1'b1;
      a_in_data  = v.d;
      a_in_mode  = v.m;
      k = 0;
      @(negedge clk);
      while (!a_in_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      acc = cyc;
      if (!a_in_ready) begin
         chk("a_send_timeout", 1'b0, k, 50);
      end else begin
         e.cnt = v.cnt; e.zero = v.z; e.norm = v.n; e.mode = v.m; e.acc = cyc; e.lat = lat;
         qa.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_b(input vec_t v, input bit lat);
      exp_t e;
      int   k;
      b_in_valid = 1'b1;
      b_in_data  = v.d[11:0];
      b_in_mode  = v.m;
      k = 0;
      @(negedge clk);
      while (!b_in_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (!b_in_ready) begin
         chk("b_send_timeout", 1'b0, k, 50);
      end else begin
         e.cnt = v.cnt; e.zero = v.z; e.norm = v.n; e.mode = v.m; e.acc = cyc; e.lat = lat;
         qb.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input bit is_b);
      int k;
      k = 0;
      while ((is_b ? qb.size() : qa.size()) != 0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (is_b) chk("b_drain", qb.size() == 0, qb.size(), 0);
      else      chk("a_drain", qa.size() == 0, qa.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   acc;
      int   n0;
      int   accs [6];
      vec_t fresh;

      rst = 1'b1;
      a_in_valid = 1'b0; a_in_data = '0; a_in_mode = '0; a_out_ready = 1'b1;
      b_in_valid = 1'b0; b_in_data = '0; b_in_mode = '0; b_out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      chk("rst_a_out_valid", a_out_valid == 1'b0, int'(a_out_valid), 0);
      chk("rst_a_out_cnt",   a_out_cnt == 5'd0, int'(a_out_cnt), 0);
      chk("rst_a_out_zero",  a_out_zero == 1'b0, int'(a_out_zero), 0);
      chk("rst_a_out_norm",  a_out_norm == 16'h0, int'(a_out_norm), 0);
      chk("rst_a_out_mode",  a_out_mode == 2'b00, int'(a_out_mode), 0);
      chk("rst_a_in_ready",  a_in_ready == 1'b1, int'(a_in_ready), 1);
      chk("rst_b_out_valid", b_out_valid == 1'b0, int'(b_out_valid), 0);
      chk("rst_b_in_ready",  b_in_ready == 1'b1, int'(b_in_ready), 1);
      @(posedge clk);
      #1;

      // Single beat, latency measured on an empty pipe.
      send_a(tbp[0], 1'b1, acc);
      a_in_valid = 1'b0;
      drain(1'b0);

      for (int i = 0; i < 13; i++) send_a(ta[i], 1'b0, acc);
      a_in_valid = 1'b0;
      drain(1'b0);

      // Backpressure: downstream stalls while six beats stream in.
      a_out_ready = 1'b0;
      n0 = a_nout;
      fork
         begin
            for (int i = 0; i < 6; i++) send_a(tbp[i], 1'b0, accs[i]);
            a_in_valid = 1'b0;
         end
         begin
            repeat (3) @(negedge clk);
            chk("a_bp_in_ready_low", a_in_ready == 1'b0, int'(a_in_ready), 0);
            repeat (2) @(posedge clk);
            #1 a_out_ready = 1'b1;
         end
      join
      drain(1'b0);
      chk("a_bp_count", (a_nout - n0) == 6, a_nout - n0, 6);
      chk("a_full_rate", (accs[5] - accs[2]) == 3, accs[5] - accs[2], 3);

      // Reset with two beats in flight.
      a_out_ready = 1'b0;
      send_a(ta[5], 1'b0, acc);
      send_a(ta[6], 1'b0, acc);
      a_in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      qa.delete();
      a_out_ready = 1'b1;
      @(negedge clk);
      chk("a_post_rst_out_valid", a_out_valid == 1'b0, int'(a_out_valid), 0);
      chk("a_post_rst_in_ready",  a_in_ready == 1'b1, int'(a_in_ready), 1);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
      fresh = ta[8];
      send_a(fresh, 1'b1, acc);
      a_in_valid = 1'b0;
      drain(1'b0);

      // Non-power-of-two width, three stages.
      send_b(tb12[0], 1'b1);
      b_in_valid = 1'b0;
      drain(1'b1);
      for (int i = 0; i < 9; i++) send_b(tb12[i], 1'b0);
      b_in_valid = 1'b0;
      drain(1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
